sfp_vec_lerp_pipe: RTL and testbench

Pipelined, flow-controlled N-lane signed fixed-point linear interpolator computing out = a + t·(b − a) per lane, i.e. (1 − t)·a + t·b with a single multiplier per lane. It is the streaming successor to the combinational vector lerp. It adds parametrised format, optional t clamping, per-lane saturation flags and a valid/ready handshake. It sits between the shading stages of the raytracer datapath, for example colour blending and ray-point evaluation.

---
 rtl/sfp_vec_lerp_pipe.sv | 124 ++++++++++++
 tb/tb_sfp_vec_lerp_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_vec_lerp_pipe.sv
// N-lane signed fixed-point lerp, out = a + t*(b - a), as a three-stage
// valid/ready pipeline that stalls as a whole when the output is blocked.
module sfp_vec_lerp_pipe #(
  parameter int N        = 3,
  parameter int IW       = 8,
  parameter int QW       = 8,
  parameter int CLIP     = 1,
  parameter int CLAMP_T  = 1,
  parameter int SHARED_T = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*(IW+QW)-1:0]    a,
  input  logic [N*(IW+QW)-1:0]    b,
  input  logic [N*(IW+QW)-1:0]    t,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*(IW+QW)-1:0]    out,
  output logic [N-1:0]            out_sat
);

  localparam int W = IW + QW;
  localparam logic signed [W-1:0] T_ONE   = {{(W-1){1'b0}}, 1'b1} << QW;
  localparam logic        [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic        [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};

  logic v1, v2, v3;
  logic en;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  // NOTE: every clocked register here uses <= so all stages sample the
  // pre-edge values of their upstream neighbours in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int TI = (SHARED_T != 0) ? 0 : i;

    logic signed [W-1:0]   a_in, b_in, t_in, tc_next;
    logic signed [W:0]     d_next;
    logic signed [W:0]     d1;
    logic signed [W-1:0]   tc1, a1, a2;
    logic signed [2*W:0]   p, q2;
    logic signed [2*W+1:0] s;
    logic        [W+2:0]   s_hi;
    logic                  in_range;
    logic        [W-1:0]   out_next, out_r;
    logic                  sat_next, sat_r;

    assign a_in = a[i*W +: W];
    assign b_in = b[i*W +: W];
    assign t_in = t[TI*W +: W];

    // One extra bit makes b - a exact for any pair of W-bit inputs.
    assign d_next = {b_in[W-1], b_in} - {a_in[W-1], a_in};

    // NOTE: tc_next is assigned before any branch so no path leaves it
    // unwritten, which would otherwise infer a latch.
    always_comb begin
      tc_next = t_in;
      if (CLAMP_T != 0) begin
        if (t_in[W-1])          tc_next = '0;
        else if (t_in > T_ONE)  tc_next = T_ONE;
      end
    end

    // Operands sign-extended to the full product width so the multiply is
    // exact regardless of operand signedness rules.
    assign p = $signed({{W{d1[W]}}, d1}) * $signed({{(W+1){tc1[W-1]}}, tc1});

    assign s        = {{(W+2){a2[W-1]}}, a2} + {q2[2*W], q2};
    assign s_hi     = s[2*W+1:W-1];
    assign in_range = (&s_hi) || !(|s_hi);

    always_comb begin
      out_next = s[W-1:0];
      sat_next = 1'b0;
      if (!in_range) begin
        sat_next = 1'b1;
        if (CLIP != 0) out_next = s[2*W+1] ? OUT_MIN : OUT_MAX;
      end
    end

    // NOTE: data registers are reset too, so out/out_sat read 0 during reset
    // and no stale operands survive into the first post-reset beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d1    <= '0;
        tc1   <= '0;
        a1    <= '0;
        q2    <= '0;
        a2    <= '0;
        out_r <= '0;
        sat_r <= 1'b0;
      end else if (en) begin
        d1    <= d_next;
        tc1   <= tc_next;
        a1    <= a_in;
        q2    <= p >>> QW;
        a2    <= a1;
        out_r <= out_next;
        sat_r <= sat_next;
      end
    end

    assign out[i*W +: W] = out_r;
    assign out_sat[i]    = sat_r;
  end

endmodule

// File: tb/tb_sfp_vec_lerp_pipe.sv
// Directed bench for sfp_vec_lerp_pipe: four parameter variants share one
// stimulus; expected lane values are hand-computed constants.
module tb_sfp_vec_lerp_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] a, b, t;

  logic [47:0] out0, out1, out2, out3;
  logic [2:0]  sat0, sat1, sat2, sat3;
  logic        ov0, ov1, ov2, ov3;
  logic        ir0, ir1, ir2, ir3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] beat_a   [6];
  logic [47:0] beat_b   [6];
  logic [47:0] beat_t   [6];
  logic [47:0] beat_exp [6];

  sfp_vec_lerp_pipe u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .t(t), .out_valid(ov0), .out_ready(out_ready),
    .out(out0), .out_sat(sat0)
  );

  sfp_vec_lerp_pipe #(.CLAMP_T(0), .CLIP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .t(t), .out_valid(ov1), .out_ready(out_ready),
    .out(out1), .out_sat(sat1)
  );

  sfp_vec_lerp_pipe #(.CLAMP_T(0), .CLIP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .a(a), .b(b), .t(t), .out_valid(ov2), .out_ready(out_ready),
    .out(out2), .out_sat(sat2)
  );

  sfp_vec_lerp_pipe #(.SHARED_T(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3),
    .a(a), .b(b), .t(t), .out_valid(ov3), .out_ready(out_ready),
    .out(out3), .out_sat(sat3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] vec(input logic [15:0] l2, l1, l0);
    return {l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one beat, then waits for u0's output; lat counts edges after accept.
  task automatic single(input logic [47:0] av, bv, tv, output int lat);
    @(negedge clk);
    a = av; b = bv; t = tv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!ov0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Streams nbeats from the beat table; rnd selects random valid/ready,
  // otherwise a single 5-cycle stall follows the first output.
  task automatic stream(input bit rnd, input int nbeats);
    logic [47:0] q[$];
    logic [47:0] held;
    int  sent, recv, stall_left;
    bit  prev_stall, seen_first;
    sent = 0; recv = 0; stall_left = 0; prev_stall = 0; seen_first = 0; held = '0;
    for (int cyc = 0; cyc < 400 && recv < nbeats; cyc++) begin
      @(negedge clk);
      if (rnd) begin
        in_valid  = (sent < nbeats) && ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid  = (sent < nbeats);
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      a = beat_a[sent % 6];
      b = beat_b[sent % 6];
      t = beat_t[sent % 6];
      #1;
      if (prev_stall) begin
        check("stall_hold_out", out0, held);
        check("stall_hold_valid", ov0, 1);
      end
      prev_stall = ov0 && !out_ready;
      if (prev_stall) begin
        check("stall_in_ready", ir0, 0);
        held = out0;
      end
      if (ov0 && out_ready) begin
        if (q.size() == 0) check("extra_beat", 1, 0);
        else check($sformatf("beat%0d", recv), out0, q.pop_front());
        check("beat_sat", sat0, 0);
        recv++;
        if (!rnd && !seen_first) begin
          seen_first = 1;
          stall_left = 5;
        end
      end
      if (in_valid && ir0) begin
        q.push_back(beat_exp[sent % 6]);
        sent++;
      end
    end
    check("stream_sent", sent, nbeats);
    check("stream_recv", recv, nbeats);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int lat;

    beat_a[0] = vec(16'h1100, 16'h0400, 16'h0000);
    beat_b[0] = vec(16'h1100, 16'h0000, 16'h0400);
    beat_t[0] = vec(16'h0080, 16'h0040, 16'h0040);
    beat_exp[0] = vec(16'h1100, 16'h0300, 16'h0100);
    beat_a[1] = vec(16'h1101, 16'h0500, 16'h0100);
    beat_b[1] = vec(16'h1101, 16'h0100, 16'h0500);
    beat_t[1] = vec(16'h0080, 16'h00C0, 16'h00C0);
    beat_exp[1] = vec(16'h1101, 16'h0200, 16'h0400);
    beat_a[2] = vec(16'h1102, 16'h0000, 16'h1000);
    beat_b[2] = vec(16'h1102, 16'h1000, 16'h0000);
    beat_t[2] = vec(16'h0080, 16'h0080, 16'h0080);
    beat_exp[2] = vec(16'h1102, 16'h0800, 16'h0800);
    beat_a[3] = vec(16'h1103, 16'h0400, 16'hFC00);
    beat_b[3] = vec(16'h1103, 16'hFC00, 16'h0400);
    beat_t[3] = vec(16'h0080, 16'h0040, 16'h0040);
    beat_exp[3] = vec(16'h1103, 16'h0200, 16'hFE00);
    beat_a[4] = vec(16'h1104, 16'h8000, 16'h7F00);
    beat_b[4] = vec(16'h1104, 16'h7F00, 16'h8000);
    beat_t[4] = vec(16'h0080, 16'h0100, 16'h0100);
    beat_exp[4] = vec(16'h1104, 16'h7F00, 16'h8000);
    beat_a[5] = vec(16'h1105, 16'h0000, 16'h0003);
    beat_b[5] = vec(16'h1105, 16'h0003, 16'h0000);
    beat_t[5] = vec(16'h0080, 16'h0055, 16'h0055);
    beat_exp[5] = vec(16'h1105, 16'h0000, 16'h0002);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; t = '0;
    #1;
    check("rst_out_valid", ov0, 0);
    check("rst_in_ready", {ir3, ir2, ir1, ir0}, 4'hF);
    check("rst_out", out0, 0);
    check("rst_out_sat", sat0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic lerp with t = 0.5, 1.0, 0 across lanes; u3 shares lane 0's t.
    single(vec(16'h0100, 16'h0100, 16'h0100), vec(16'h0300, 16'h0300, 16'h0300),
           vec(16'h0000, 16'h0100, 16'h0080), lat);
    check("basic_latency", lat, 3);
    check("basic_out", out0, vec(16'h0100, 16'h0300, 16'h0200));
    check("basic_sat", sat0, 0);
    check("shared_valid", ov3, 1);
    check("shared_out", out3, vec(16'h0200, 16'h0200, 16'h0200));
    @(negedge clk);
    check("basic_valid_drop", ov0, 0);

    // Rounding on lane 0, overshoot t=2.0 on lane 1, t=-1.0 on lane 2.
    single(vec(16'h0000, 16'h0000, 16'h0000), vec(16'h6400, 16'h6400, 16'hFFFF),
           vec(16'hFF00, 16'h0200, 16'h0080), lat);
    check("round_latency", lat, 3);
    check("clamp_out", out0, vec(16'h0000, 16'h6400, 16'hFFFF));
    check("clamp_sat", sat0, 0);
    check("clip_valid", ov1 & ov2, 1);
    check("clip_out", out1, vec(16'h9C00, 16'h7FFF, 16'hFFFF));
    check("clip_sat", sat1, 3'b010);
    check("wrap_out", out2, vec(16'h9C00, 16'hC800, 16'hFFFF));
    check("wrap_sat", sat2, 3'b010);
    check("shared_out2", out3, vec(16'h3200, 16'h3200, 16'hFFFF));

    // Negative overflow: a=-112, b=+112, t=-1.0.
    single(vec(16'h0000, 16'h0000, 16'h9000), vec(16'h0000, 16'h0000, 16'h7000),
           vec(16'h0000, 16'h0000, 16'hFF00), lat);
    check("neg_latency", lat, 3);
    check("neg_clamp_out", out0, vec(16'h0000, 16'h0000, 16'h9000));
    check("neg_clip_out", out1, vec(16'h0000, 16'h0000, 16'h8000));
    check("neg_clip_sat", sat1, 3'b001);
    check("neg_wrap_out", out2, vec(16'h0000, 16'h0000, 16'hB000));
    check("neg_wrap_sat", sat2, 3'b001);
    check("neg_shared_out", out3, vec(16'h0000, 16'h0000, 16'h9000));

    stream(1'b0, 6);
    stream(1'b1, 12);
    repeat (4) @(negedge clk);

    // Fill all three stages while the output is blocked, then reset mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = beat_a[k]; b = beat_b[k]; t = beat_t[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_out_valid", ov0, 1);
    check("full_out", out0, beat_exp[0]);
    check("full_in_ready", ir0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov0, 0);
    check("midrst_out", out0, 0);
    check("midrst_out_sat", {sat2, sat1, sat0}, 0);
    check("midrst_in_ready", ir0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    single(beat_a[5], beat_b[5], beat_t[5], lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_out", out0, beat_exp[5]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
